// File: rtl/mem_stage_lsu_if.sv
// EX/MEM operation, data-memory bus and MEM/WB result signals of the load/store unit.
// master = the LSU itself, slave = the surrounding pipeline and memory.
interface mem_stage_lsu_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_crt_wb;

    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_read_data;
    logic [31:0] wb_alu_result;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_crt_wb;
    logic        bus_err;

    modport master (
        input  ex_valid, ex_mem_rd, ex_mem_wr, ex_funct3, ex_addr, ex_wdata, ex_rd, ex_crt_wb,
        output ex_ready,
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output wb_valid, wb_read_data, wb_alu_result, wb_rd, wb_crt_wb, bus_err,
        input  wb_ready
    );

    modport slave (
        output ex_valid, ex_mem_rd, ex_mem_wr, ex_funct3, ex_addr, ex_wdata, ex_rd, ex_crt_wb,
        input  ex_ready,
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  wb_valid, wb_read_data, wb_alu_result, wb_rd, wb_crt_wb, bus_err,
        output wb_ready
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32I memory-stage LSU: req/gnt/rvalid data access, load align/extend, registered MEM/WB result.
// Latency: non-mem 1, store >=2, load >=3 cycles; WAIT_RSP aborts with bus_err after DMEM_TIMEOUT cycles.
// Backpressure: ex_ready only in IDLE with the result slot free; LSU_MISALIGN_TRAP_EN adds misalign trapping.
module mem_stage_lsu #(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    mem_stage_lsu_if.master bus
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);
    localparam int CW = $clog2(DMEM_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, HOLD} state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  crt_q, crt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        wbv_q, wbv_d, err_q, err_d;
    logic [31:0] wbd_q, wbd_d, wba_q, wba_d;
    logic [4:0]  wbrd_q, wbrd_d;
    logic [1:0]  wbc_q, wbc_d;
    logic [31:0] pd_q, pd_d, pa_q, pa_d;
    logic [4:0]  prd_q, prd_d;
    logic [1:0]  pc_q, pc_d;

    logic        wb_free, accept, mem_op, trap;
    logic        res_fire, res_err;
    logic [31:0] res_data;
    logic [1:0]  res_crt;
    logic [1:0]  sz, a;

    assign wb_free = !wbv_q || bus.wb_ready;
    assign bus.ex_ready = (state_q == IDLE) && wb_free;
    assign accept = bus.ex_valid && bus.ex_ready;
    assign mem_op = bus.ex_mem_rd || bus.ex_mem_wr;
    assign sz = bus.ex_funct3[1:0];
    assign a  = bus.ex_addr[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign trap = mem_op && ((sz == 2'b01 && a[0]) || (sz[1] && a != 2'b00));
    assign misalign = mis_q;
`else
    assign trap = 1'b0;
`endif

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;  tmo_d = tmo_q;
        f3_d = f3_q;  off_d = off_q;  alu_d = alu_q;  rd_d = rd_q;  crt_d = crt_q;
        req_d = req_q;  we_d = we_q;  be_d = be_q;  addr_d = addr_q;  wdata_d = wdata_q;
        wbv_d = wbv_q;  wbd_d = wbd_q;  wba_d = wba_q;  wbrd_d = wbrd_q;  wbc_d = wbc_q;
        pd_d = pd_q;  pa_d = pa_q;  prd_d = prd_q;  pc_d = pc_q;
        err_d = 1'b0;
        res_fire = 1'b0;  res_err = 1'b0;  res_data = 32'd0;  res_crt = crt_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d = 1'b0;
`endif
        if (wbv_q && bus.wb_ready) wbv_d = 1'b0;

        case (state_q)
            IDLE: if (accept) begin
                f3_d = bus.ex_funct3;  off_d = a;  alu_d = bus.ex_addr;
                rd_d = bus.ex_rd;  crt_d = bus.ex_crt_wb;
                if (mem_op && !trap) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = bus.ex_mem_wr;
                    addr_d  = {bus.ex_addr[31:2], 2'b00};
                    case (sz)
                        2'b00:   begin be_d = 4'b0001 << a; wdata_d = {4{bus.ex_wdata[7:0]}}; end
                        2'b01:   begin be_d = a[1] ? 4'b1100 : 4'b0011; wdata_d = {2{bus.ex_wdata[15:0]}}; end
                        default: begin be_d = 4'b1111; wdata_d = bus.ex_wdata; end
                    endcase
                end else begin
                    wbv_d = 1'b1;  wbd_d = 32'd0;  wba_d = bus.ex_addr;  wbrd_d = bus.ex_rd;
                    wbc_d = trap ? 2'b00 : bus.ex_crt_wb;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_d = trap;
`endif
                end
            end
            // rvalid is not looked at here: a response alongside gnt is illegal on this bus
            REQ: if (bus.dmem_gnt) begin
                req_d = 1'b0;
                we_d  = 1'b0;
                tmo_d = '0;
                if (we_q) res_fire = 1'b1;
                else      state_d  = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (bus.dmem_rvalid) begin
                    res_fire = 1'b1;
                    res_data = load_ext(bus.dmem_rdata, f3_q, off_q);
                end else if (tmo_q == CW'(DMEM_TIMEOUT - 1)) begin
                    res_fire = 1'b1;
                    res_err  = 1'b1;
                    res_crt  = 2'b00;
                end
                tmo_d = res_fire ? '0 : tmo_q + CW'(1);
            end
            HOLD: if (bus.wb_ready) begin
                wbv_d = 1'b1;  wbd_d = pd_q;  wba_d = pa_q;  wbrd_d = prd_q;  wbc_d = pc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (res_fire) begin
            err_d = res_err;
            if (wb_free) begin
                wbv_d = 1'b1;  wbd_d = res_data;  wba_d = alu_q;  wbrd_d = rd_q;  wbc_d = res_crt;
                state_d = IDLE;
            end else begin
                pd_d = res_data;  pa_d = alu_q;  prd_d = rd_q;  pc_d = res_crt;
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;  tmo_q <= '0;
            f3_q <= '0;  off_q <= '0;  alu_q <= '0;  rd_q <= '0;  crt_q <= '0;
            req_q <= 1'b0;  we_q <= 1'b0;  be_q <= '0;  addr_q <= '0;  wdata_q <= '0;
            wbv_q <= 1'b0;  wbd_q <= '0;  wba_q <= '0;  wbrd_q <= '0;  wbc_q <= '0;
            pd_q <= '0;  pa_q <= '0;  prd_q <= '0;  pc_q <= '0;  err_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;  tmo_q <= tmo_d;
            f3_q <= f3_d;  off_q <= off_d;  alu_q <= alu_d;  rd_q <= rd_d;  crt_q <= crt_d;
            req_q <= req_d;  we_q <= we_d;  be_q <= be_d;  addr_q <= addr_d;  wdata_q <= wdata_d;
            wbv_q <= wbv_d;  wbd_q <= wbd_d;  wba_q <= wba_d;  wbrd_q <= wbrd_d;  wbc_q <= wbc_d;
            pd_q <= pd_d;  pa_q <= pa_d;  prd_q <= prd_d;  pc_q <= pc_d;  err_q <= err_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q <= mis_d;
`endif
        end
    end

    assign bus.dmem_req      = req_q;
    assign bus.dmem_we       = we_q;
    assign bus.dmem_be       = be_q;
    assign bus.dmem_addr     = addr_q;
    assign bus.dmem_wdata    = wdata_q;
    assign bus.wb_valid      = wbv_q;
    assign bus.wb_read_data  = wbd_q;
    assign bus.wb_alu_result = wba_q;
    assign bus.wb_rd         = wbrd_q;
    assign bus.wb_crt_wb     = wbc_q;
    assign bus.bus_err       = err_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed plus randomized bench for mem_stage_lsu against an arithmetic reference model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_stage_lsu;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   ntests = 0;
    int   nfail  = 0;

    mem_stage_lsu_if bus_if();
`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    mem_stage_lsu #(.DMEM_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus_if), .misalign(misalign));
`else
    mem_stage_lsu #(.DMEM_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus_if));
`endif

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: byte lanes computed with shifts and plain arithmetic.
    function automatic logic [31:0] m_load(input logic [2:0] f3, input int unsigned a, input int unsigned w);
        int unsigned b, h;
        b = (w >> (8 * a)) % 256;
        h = (w >> (16 * (a / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] f3, input int unsigned a);
        if (f3 % 4 == 0) return 1 << a;
        if (f3 % 4 == 1) return (a >= 2) ? 12 : 3;
        return 15;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input int unsigned w);
        if (f3 % 4 == 0) return (w % 256) * 32'h01010101;
        if (f3 % 4 == 1) return (w % 65536) * 32'h00010001;
        return w;
    endfunction

    function automatic logic m_misal(input logic [2:0] f3, input int unsigned a);
        if (f3 % 4 == 1) return (a % 2) == 1;
        if (f3 % 4 >= 2) return a != 0;
        return 1'b0;
    endfunction

    // Everything after the accepting edge: bus phase, response, and the result beat.
    task automatic tail(input logic st, input logic mem, input logic trap, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input logic [4:0] rdv, input logic [1:0] crt, input int gdly, input int rdly);
        if (!mem || trap) begin
            @(negedge clk);
            chk("direct wb_valid", bus_if.wb_valid, 1);
            chk("direct read_data", bus_if.wb_read_data, 0);
            chk("direct alu_result", bus_if.wb_alu_result, addr);
            chk("direct rd", bus_if.wb_rd, rdv);
            chk("direct crt_wb", bus_if.wb_crt_wb, trap ? 2'b00 : crt);
            chk("direct no dmem_req", bus_if.dmem_req, 0);
`ifdef LSU_MISALIGN_TRAP_EN
            chk("misalign pulse", misalign, trap);
`endif
            step();
            return;
        end
        for (int k = 0; k <= gdly; k++) begin
            bus_if.dmem_gnt = (k == gdly);
            @(negedge clk);
            chk("req dmem_req", bus_if.dmem_req, 1);
            chk("req dmem_we", bus_if.dmem_we, st);
            chk("req dmem_be", bus_if.dmem_be, m_be(f3, addr % 4));
            chk("req dmem_addr", bus_if.dmem_addr, addr - addr % 4);
            if (st) chk("req dmem_wdata", bus_if.dmem_wdata, m_wd(f3, wd));
            chk("req no wb_valid", bus_if.wb_valid, 0);
            step();
        end
        bus_if.dmem_gnt = 1'b0;
        if (st) begin
            @(negedge clk);
            chk("st wb_valid", bus_if.wb_valid, 1);
            chk("st read_data", bus_if.wb_read_data, 0);
            chk("st alu_result", bus_if.wb_alu_result, addr);
            chk("st rd", bus_if.wb_rd, rdv);
            chk("st crt_wb", bus_if.wb_crt_wb, crt);
            chk("st req dropped", bus_if.dmem_req, 0);
            step();
        end else if (rdly >= TMO) begin
            for (int k = 0; k < TMO; k++) begin
                @(negedge clk);
                chk("tmo waiting wb_valid", bus_if.wb_valid, 0);
                step();
            end
            @(negedge clk);
            chk("tmo wb_valid", bus_if.wb_valid, 1);
            chk("tmo bus_err", bus_if.bus_err, 1);
            chk("tmo read_data", bus_if.wb_read_data, 0);
            chk("tmo crt_wb", bus_if.wb_crt_wb, 0);
            chk("tmo rd", bus_if.wb_rd, rdv);
            step();
            @(negedge clk);
            chk("tmo bus_err one cycle", bus_if.bus_err, 0);
            chk("tmo back to idle", bus_if.ex_ready, 1);
            step();
        end else begin
            for (int k = 0; k < rdly; k++) begin
                @(negedge clk);
                chk("ld waiting wb_valid", bus_if.wb_valid, 0);
                step();
            end
            bus_if.dmem_rvalid = 1'b1;
            bus_if.dmem_rdata  = rdata;
            @(negedge clk);
            chk("ld rvalid cycle wb_valid", bus_if.wb_valid, 0);
            step();
            bus_if.dmem_rvalid = 1'b0;
            bus_if.dmem_rdata  = $urandom;
            @(negedge clk);
            chk("ld wb_valid", bus_if.wb_valid, 1);
            chk("ld read_data", bus_if.wb_read_data, m_load(f3, addr % 4, rdata));
            chk("ld alu_result", bus_if.wb_alu_result, addr);
            chk("ld rd", bus_if.wb_rd, rdv);
            chk("ld crt_wb", bus_if.wb_crt_wb, crt);
            chk("ld bus_err", bus_if.bus_err, 0);
            step();
        end
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int gdly, input int rdly);
        logic       trap;
        logic [4:0] rdv;
        logic [1:0] crt;
        rdv  = 5'($urandom);
        crt  = 2'($urandom);
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (rd || wr) && m_misal(f3, addr % 4);
`endif
        bus_if.ex_valid  = 1'b1;
        bus_if.ex_mem_rd = rd;
        bus_if.ex_mem_wr = wr;
        bus_if.ex_funct3 = f3;
        bus_if.ex_addr   = addr;
        bus_if.ex_wdata  = wd;
        bus_if.ex_rd     = rdv;
        bus_if.ex_crt_wb = crt;
        @(negedge clk);
        chk("issue ex_ready", bus_if.ex_ready, 1);
        step();
        bus_if.ex_valid = 1'b0;
        tail(wr, rd || wr, trap, f3, addr, wd, rdata, rdv, crt, gdly, rdly);
    endtask

    initial begin
        logic [2:0] ld_f3 [6];
        logic [2:0] f3;
        int         kind;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

        bus_if.ex_valid = 0;  bus_if.ex_mem_rd = 0;  bus_if.ex_mem_wr = 0;  bus_if.ex_funct3 = 0;
        bus_if.ex_addr = 0;   bus_if.ex_wdata = 0;   bus_if.ex_rd = 0;      bus_if.ex_crt_wb = 0;
        bus_if.dmem_gnt = 0;  bus_if.dmem_rvalid = 0; bus_if.dmem_rdata = 0; bus_if.wb_ready = 1;
        rst = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst dmem_req", bus_if.dmem_req, 0);
        chk("rst dmem_be", bus_if.dmem_be, 0);
        chk("rst dmem_addr", bus_if.dmem_addr, 0);
        chk("rst wb_valid", bus_if.wb_valid, 0);
        chk("rst bus_err", bus_if.bus_err, 0);
        chk("rst wb_read_data", bus_if.wb_read_data, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("post-rst ex_ready", bus_if.ex_ready, 1);
        step();

        // LB / LBU at 0x1003: byte 3 of 0x80FF0000 is 0x80
        do_op(1, 0, 3'b000, 32'h0000_1003, 0, 32'h80FF_0000, 0, 0);
        do_op(1, 0, 3'b100, 32'h0000_1003, 0, 32'h80FF_0000, 0, 0);
        // SH at 0x2002 with grant delayed three cycles
        do_op(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 0, 3, 0);
        // LW at 0x3001: trapped with the feature, forced to 0x3000 / be 1111 without it
        do_op(1, 0, 3'b010, 32'h0000_3001, 0, 32'h1234_5678, 0, 1);
        // Load with no response: timeout
        do_op(1, 0, 3'b010, 32'h0000_0040, 0, 0, 0, TMO);

        // Non-mem result held by wb_ready=0 while a load waits upstream
        bus_if.wb_ready  = 1'b0;
        bus_if.ex_valid  = 1'b1;  bus_if.ex_mem_rd = 0;  bus_if.ex_mem_wr = 0;
        bus_if.ex_addr   = 32'h55AA_0010;  bus_if.ex_rd = 5'd7;  bus_if.ex_crt_wb = 2'b01;
        @(negedge clk);
        chk("hold first accept", bus_if.ex_ready, 1);
        step();
        bus_if.ex_mem_rd = 1;  bus_if.ex_funct3 = 3'b010;  bus_if.ex_addr = 32'h4000_0008;
        bus_if.ex_rd = 5'd9;   bus_if.ex_crt_wb = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold wb_valid", bus_if.wb_valid, 1);
            chk("hold alu_result", bus_if.wb_alu_result, 32'h55AA_0010);
            chk("hold rd", bus_if.wb_rd, 7);
            chk("hold crt_wb", bus_if.wb_crt_wb, 2'b01);
            chk("hold ex_ready low", bus_if.ex_ready, 0);
            chk("hold no dmem_req", bus_if.dmem_req, 0);
            step();
        end
        bus_if.wb_ready = 1'b1;
        @(negedge clk);
        chk("hold release ex_ready", bus_if.ex_ready, 1);
        step();
        bus_if.ex_valid = 1'b0;
        tail(0, 1, 0, 3'b010, 32'h4000_0008, 0, 32'hCAFE_F00D, 5'd9, 2'b11, 1, 2);

        // Reset while waiting for a load response; the late rvalid must be dropped
        bus_if.ex_valid = 1'b1;  bus_if.ex_mem_rd = 1;  bus_if.ex_mem_wr = 0;
        bus_if.ex_funct3 = 3'b010;  bus_if.ex_addr = 32'h0000_0100;
        @(negedge clk);
        step();
        bus_if.ex_valid = 1'b0;
        bus_if.dmem_gnt = 1'b1;
        @(negedge clk);
        chk("rstmid req", bus_if.dmem_req, 1);
        step();
        bus_if.dmem_gnt = 1'b0;
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("rstmid dmem_req", bus_if.dmem_req, 0);
        chk("rstmid wb_valid", bus_if.wb_valid, 0);
        step();
        rst = 1'b1;
        bus_if.dmem_rvalid = 1'b1;
        bus_if.dmem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rstmid ex_ready", bus_if.ex_ready, 1);
        step();
        bus_if.dmem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rstmid late rvalid ignored", bus_if.wb_valid, 0);
            step();
        end

        // Randomized mix of non-mem, load and store operations
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                do_op(0, 0, 3'($urandom), $urandom, $urandom, 0, 0, 0);
            end else if (kind == 1) begin
                f3 = ld_f3[$urandom_range(0, 5)];
                do_op(1, 0, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 4));
            end else begin
                f3 = 3'($urandom_range(0, 2));
                do_op(1'($urandom), 1, f3, $urandom, $urandom, 0, $urandom_range(0, 3), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
